sobel_edge_filter: RTL and testbench
====================================

Name: sobel_edge_filter

Overview:
- Streaming 3x3 Sobel edge detector for one 8-bit greyscale frame held in an external synchronous image ROM.
- Reads the frame through an address/data port, computes |Gx|+|Gy| per interior pixel and thresholds it to a binary black/white edge pixel with a linear write address.
- Sits between the image ROM and the edge-image store; runs in the 75 MHz domain behind the clock generator's locked flag.

Parameters:
- IMG_W, 224, frame width in pixels.
- IMG_H, 224, frame height in pixels.
- THRESH, 200, edge threshold on |Gx|+|Gy|.

Ports:
- clk_75  input  1  system clock; all logic on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- start  input  1  frame start request, one-cycle pulse or level.
- locked  input  1  clock-generator locked; frame runs only while high.
- rom_addr  output  16  image ROM read address = row*IMG_W + col.
- rom_data  input  8  ROM read data, valid exactly 1 cycle after rom_addr.
- out  output  8  edge pixel: 0 = edge, 255 = no edge.
- addr_edge  output  16  linear address of out in the (IMG_W-2)x(IMG_H-2) output image.
- out_valid  output  1  one-cycle strobe: out/addr_edge hold a new pixel.
- finished  output  1  frame complete; held high until next accepted start or RESET.

Behaviour:
- Reset values: out=0, addr_edge=0, out_valid=0, finished=0, rom_addr=0. FSM returns to IDLE; window registers and counters are cleared.
- RESET has priority over everything, including mid-frame.
- IDLE: start=1 and locked=1 moves the FSM to RUN, clears finished, and zeroes band row r and column c.
- In IDLE, start is ignored while locked=0.
- In RUN, start is ignored.
- RUN fetch order: for each band r=0..IMG_H-3 and each column c=0..IMG_W-1, issue 3 consecutive reads: rows r, r+1, r+2 at column c. This gives one read per cycle and 3 cycles per column.
- Each returned pixel is shifted into its window row. Per window row: p[k][0]<=p[k][1], p[k][1]<=p[k][2], p[k][2]<=new.
- After all 3 rows of column c are loaded and c>=2, the window covers columns c-2..c.
  - Gx = (p00+2p10+p20) - (p02+2p12+p22).
  - Gy = (p00+2p01+p02) - (p20+2p21+p22).
  - p[row][col] indexing; signed, at least 12 bits.
  - A = |Gx|+|Gy|, unsigned, at least 12 bits, max 2040.
  - out = 0 if A >= THRESH, else 255.
- Output pixel index = r*(IMG_W-2) + (c-2), so addr_edge counts 0..(IMG_W-2)*(IMG_H-2)-1 = 0..49283 in order.
- Latency: out_valid rises exactly 3 cycles after the cycle in which rom_data for p22 is sampled.
- out and addr_edge hold their values between strobes.
- Columns c=0,1 of each band only prime the window and produce no output. The window is flushed at each new band.
- Frame end: in the cycle after the strobe for addr_edge=49283, finished=1 and FSM=IDLE. Exactly 49284 strobes occur per frame.
- locked falling during RUN: abort to IDLE, finished stays 0, no further strobes. Pipeline results in flight are discarded. A new start restarts from pixel 0.
- Widths: rom_addr and addr_edge 16 bits; no wrap occurs for the defaults.

Test Plan:
- Uniform frame, all pixels 100; start pulse with locked=1 -> 49284 strobes, all out=255, addr_edge 0..49283 contiguous, finished=1 one cycle after last strobe.
- Vertical step, pixel = 0 for col<112 and 255 otherwise -> |Gx|=1020. out=0 exactly at output columns 110 and 111 of every row, 255 elsewhere.
- Horizontal step, pixel = 0 for row<112 and 255 otherwise -> out=0 for output rows 110 and 111 only.
- Threshold boundary, vertical step of height 50 (A=200) -> out=0 on the step columns. Height 49 (A=196) -> out=255 everywhere.
- RESET asserted mid-frame at addr_edge≈1000 -> next cycle all outputs at reset values. New start -> full 49284-pixel frame from addr_edge=0.
- start while locked=0 -> no rom_addr activity. start during RUN -> ignored. locked dropped mid-frame -> strobes stop, finished stays 0.

Source files
------------

// File: rtl/sobel_edge_filter.sv
// Streaming 3x3 Sobel edge detector over a frame in a 1-cycle synchronous ROM; out_valid 3 cycles after p22 data.
// No backpressure: one ROM read per cycle, 3 reads per column; locked low aborts, RESET overrides all.
module sobel_edge_filter #(
  parameter int IMG_W  = 224,
  parameter int IMG_H  = 224,
  parameter int THRESH = 200
) (
  input  logic        clk_75,
  input  logic        RESET,
  input  logic        start,
  input  logic        locked,
  output logic [15:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [7:0]  out,
  output logic [15:0] addr_edge,
  output logic        out_valid,
  output logic        finished
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] C_LAST   = CW'(IMG_W - 1);
  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [CW-1:0] C_TWO    = CW'(2);
  localparam logic [RW-1:0] R_LAST   = RW'(IMG_H - 3);
  localparam logic [RW-1:0] R_ONE    = RW'(1);
  localparam logic [15:0]   PIX_LAST = 16'((IMG_W - 2) * (IMG_H - 2) - 1);
  localparam logic [11:0]   THR      = 12'(THRESH);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        state_q, state_d;
  logic          finished_q, finished_d;
  logic          iss_vld_q, iss_vld_d;
  logic [RW-1:0] iss_r_q, iss_r_d;
  logic [CW-1:0] iss_c_q, iss_c_d;
  logic [1:0]    iss_k_q, iss_k_d;
  logic [15:0]   rom_addr_q, rom_addr_d;
  logic          dat_vld_q, dat_vld_d;
  logic [1:0]    dat_k_q, dat_k_d;
  logic [CW-1:0] dat_c_q, dat_c_d;
  logic [7:0]    win_q [0:2][0:2];
  logic [7:0]    win_d [0:2][0:2];
  logic          s0_vld_q, s0_vld_d;
  logic          g_vld_q, g_vld_d;
  logic signed [11:0] gx_q, gx_d, gy_q, gy_d;
  logic [7:0]    out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic [15:0]   addr_edge_q, addr_edge_d;
  logic [15:0]   pix_cnt_q, pix_cnt_d;

  logic signed [11:0] gx_c, gy_c;
  logic [11:0]        gx_abs, gy_abs, a_sum;
  logic [15:0]        row_sel;

  function automatic logic signed [11:0] px(input logic [7:0] v);
    return $signed({4'b0000, v});
  endfunction

  // Window is [row][col], col 2 holding the most recently fetched column.
  always_comb begin
    gx_c = (px(win_q[0][0]) + (px(win_q[1][0]) <<< 1) + px(win_q[2][0]))
         - (px(win_q[0][2]) + (px(win_q[1][2]) <<< 1) + px(win_q[2][2]));
    gy_c = (px(win_q[0][0]) + (px(win_q[0][1]) <<< 1) + px(win_q[0][2]))
         - (px(win_q[2][0]) + (px(win_q[2][1]) <<< 1) + px(win_q[2][2]));
    gx_abs = gx_q[11] ? 12'(-gx_q) : 12'(gx_q);
    gy_abs = gy_q[11] ? 12'(-gy_q) : 12'(gy_q);
    a_sum  = gx_abs + gy_abs;
  end

  always_comb begin
    state_d     = state_q;
    finished_d  = finished_q;
    iss_vld_d   = 1'b0;
    iss_r_d     = iss_r_q;
    iss_c_d     = iss_c_q;
    iss_k_d     = iss_k_q;
    rom_addr_d  = rom_addr_q;
    dat_vld_d   = 1'b0;
    dat_k_d     = dat_k_q;
    dat_c_d     = dat_c_q;
    win_d       = win_q;
    s0_vld_d    = 1'b0;
    g_vld_d     = 1'b0;
    gx_d        = gx_q;
    gy_d        = gy_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    addr_edge_d = addr_edge_q;
    pix_cnt_d   = pix_cnt_q;
    row_sel     = 16'(iss_r_q) + 16'(iss_k_q);

    case (state_q)
      S_IDLE: begin
        if (start && locked) begin
          state_d    = S_RUN;
          finished_d = 1'b0;
          iss_vld_d  = 1'b1;
          iss_r_d    = '0;
          iss_c_d    = '0;
          iss_k_d    = '0;
          rom_addr_d = '0;
          pix_cnt_d  = '0;
        end
      end
      S_RUN: begin
        if (!locked) begin
          // Everything in flight is dropped by the default-cleared valids.
          state_d = S_IDLE;
        end else begin
          if (iss_vld_q) begin
            iss_vld_d = 1'b1;
            if (iss_k_q != 2'd2) begin
              iss_k_d = iss_k_q + 2'd1;
            end else begin
              iss_k_d = 2'd0;
              if (iss_c_q != C_LAST) begin
                iss_c_d = iss_c_q + C_ONE;
              end else begin
                iss_c_d = '0;
                if (iss_r_q != R_LAST) iss_r_d = iss_r_q + R_ONE;
                else                   iss_vld_d = 1'b0;
              end
            end
            row_sel = 16'(iss_r_d) + 16'(iss_k_d);
            if (iss_vld_d) rom_addr_d = row_sel * 16'(IMG_W) + 16'(iss_c_d);
          end

          dat_vld_d = iss_vld_q;
          dat_k_d   = iss_k_q;
          dat_c_d   = iss_c_q;

          if (dat_vld_q) begin
            for (int k = 0; k < 3; k++) begin
              if (dat_k_q == 2'(k)) begin
                win_d[k][0] = win_q[k][1];
                win_d[k][1] = win_q[k][2];
                win_d[k][2] = rom_data;
              end
            end
          end
          s0_vld_d = dat_vld_q && (dat_k_q == 2'd2) && (dat_c_q >= C_TWO);

          g_vld_d = s0_vld_q;
          if (s0_vld_q) begin
            gx_d = gx_c;
            gy_d = gy_c;
          end

          // Outputs leave strictly in raster order, so a running count is the address.
          if (g_vld_q) begin
            out_valid_d = 1'b1;
            out_d       = (a_sum >= THR) ? 8'd0 : 8'd255;
            addr_edge_d = pix_cnt_q;
            pix_cnt_d   = pix_cnt_q + 16'd1;
          end

          if (out_valid_q && (addr_edge_q == PIX_LAST)) begin
            state_d    = S_IDLE;
            finished_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_75) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      finished_q  <= 1'b0;
      iss_vld_q   <= 1'b0;
      iss_r_q     <= '0;
      iss_c_q     <= '0;
      iss_k_q     <= '0;
      rom_addr_q  <= '0;
      dat_vld_q   <= 1'b0;
      dat_k_q     <= '0;
      dat_c_q     <= '0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) win_q[i][j] <= '0;
      end
      s0_vld_q    <= 1'b0;
      g_vld_q     <= 1'b0;
      gx_q        <= '0;
      gy_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      addr_edge_q <= '0;
      pix_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      finished_q  <= finished_d;
      iss_vld_q   <= iss_vld_d;
      iss_r_q     <= iss_r_d;
      iss_c_q     <= iss_c_d;
      iss_k_q     <= iss_k_d;
      rom_addr_q  <= rom_addr_d;
      dat_vld_q   <= dat_vld_d;
      dat_k_q     <= dat_k_d;
      dat_c_q     <= dat_c_d;
      win_q       <= win_d;
      s0_vld_q    <= s0_vld_d;
      g_vld_q     <= g_vld_d;
      gx_q        <= gx_d;
      gy_q        <= gy_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      addr_edge_q <= addr_edge_d;
      pix_cnt_q   <= pix_cnt_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign out       = out_q;
  assign addr_edge = addr_edge_q;
  assign out_valid = out_valid_q;
  assign finished  = finished_q;

endmodule

// File: tb/tb_sobel_edge_filter.sv
// Bench for sobel_edge_filter on a reduced 16x12 frame: a direct-definition Sobel model
// plus literal pins, a per-cycle output compare process, and directed control scenarios.
module tb_sobel_edge_filter;

  localparam int W  = 16;
  localparam int H  = 12;
  localparam int N  = (W - 2) * (H - 2);
  localparam int TH = 200;

  logic        clk_75 = 1'b0;
  logic        RESET;
  logic        start;
  logic        locked;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  out;
  logic [15:0] addr_edge;
  logic        out_valid;
  logic        finished;

  sobel_edge_filter #(.IMG_W(W), .IMG_H(H), .THRESH(TH)) dut (
    .clk_75   (clk_75),
    .RESET    (RESET),
    .start    (start),
    .locked   (locked),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .out      (out),
    .addr_edge(addr_edge),
    .out_valid(out_valid),
    .finished (finished)
  );

  always #5 clk_75 = ~clk_75;

  logic [7:0] mem [256];
  int exp_out [N];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int vld_seen = 0;
  int acc_cyc = 0;
  int last_strobe_cyc = 0;
  bit chk_en = 1'b0;
  bit fin_prev = 1'b0;

  // Synchronous ROM: data appears the cycle after the address.
  always @(posedge clk_75) begin
    rom_data <= mem[rom_addr[7:0]];
    cyc      <= cyc + 1;
  end

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic load_img(input int kind, input int hgt);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (kind)
          0:       mem[r*W + c] = 8'd100;
          1:       mem[r*W + c] = (c < W/2) ? 8'd0 : 8'(hgt);
          2:       mem[r*W + c] = (r < H/2) ? 8'd0 : 8'(hgt);
          default: mem[r*W + c] = 8'($urandom_range(0, 80));
        endcase
      end
    end
  endtask

  task automatic build_expected();
    int p [3][3];
    int gx, gy;
    for (int orow = 0; orow < H - 2; orow++) begin
      for (int ocol = 0; ocol < W - 2; ocol++) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            p[i][j] = int'(mem[(orow + i)*W + ocol + j]);
        gx = (p[0][0] + 2*p[1][0] + p[2][0]) - (p[0][2] + 2*p[1][2] + p[2][2]);
        gy = (p[0][0] + 2*p[0][1] + p[0][2]) - (p[2][0] + 2*p[2][1] + p[2][2]);
        exp_out[orow*(W - 2) + ocol] = (iabs(gx) + iabs(gy) >= TH) ? 0 : 255;
      end
    end
  endtask

  always @(negedge clk_75) begin
    if (out_valid) vld_seen++;
    if (chk_en) begin
      if (out_valid) begin
        check("addr_seq", int'(addr_edge), strobe_cnt);
        if (strobe_cnt < N) check("pixel", int'(out), exp_out[strobe_cnt]);
        else                check("extra_strobe", strobe_cnt, N - 1);
        if (strobe_cnt == 0) check("first_latency", cyc - acc_cyc, 12);
        last_strobe_cyc = cyc;
        strobe_cnt++;
      end else if (strobe_cnt > 0) begin
        check("addr_hold", int'(addr_edge), strobe_cnt - 1);
      end
      if (finished && !fin_prev) begin
        check("fin_count", strobe_cnt, N);
        check("fin_delay", cyc - last_strobe_cyc, 1);
      end
    end
    fin_prev = finished;
  end

  task automatic tick();
    @(posedge clk_75);
    #1;
  endtask

  task automatic start_frame();
    strobe_cnt = 0;
    chk_en     = 1'b1;
    start      = 1'b1;
    tick();
    acc_cyc = cyc;
    start   = 1'b0;
    check("fin_clear", int'(finished), 0);
  endtask

  task automatic run_frame(input bit mid_start);
    int n;
    start_frame();
    n = 0;
    while (!finished && n < 2000) begin
      if (mid_start && n == 60) start = 1'b1;
      if (mid_start && n == 62) start = 1'b0;
      tick();
      n++;
    end
    start = 1'b0;
    if (!finished) check("frame_timeout", 0, 1);
    repeat (3) tick();
    check("fin_hold", int'(finished), 1);
  endtask

  task automatic wait_strobes(input int target);
    int n;
    n = 0;
    while (strobe_cnt < target && n < 2000) begin
      tick();
      n++;
    end
    if (strobe_cnt < target) check("strobe_timeout", strobe_cnt, target);
  endtask

  initial begin
    int snap;
    int ra;
    RESET  = 1'b1;
    start  = 1'b0;
    locked = 1'b1;
    repeat (3) tick();
    check("rst_out", int'(out), 0);
    check("rst_addr_edge", int'(addr_edge), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_finished", int'(finished), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    RESET = 1'b0;
    tick();

    load_img(0, 0);
    build_expected();
    check("pin_uniform", exp_out[0], 255);
    run_frame(1'b0);

    load_img(1, 255);
    build_expected();
    check("pin_v_col5", exp_out[5], 255);
    check("pin_v_col6", exp_out[6], 0);
    check("pin_v_col7", exp_out[7], 0);
    check("pin_v_col8", exp_out[8], 255);
    run_frame(1'b0);

    load_img(2, 255);
    build_expected();
    check("pin_h_row3", exp_out[3*(W-2) + 3], 255);
    check("pin_h_row4", exp_out[4*(W-2) + 3], 0);
    check("pin_h_row5", exp_out[5*(W-2) + 3], 0);
    check("pin_h_row6", exp_out[6*(W-2) + 3], 255);
    run_frame(1'b1);

    load_img(1, 50);
    build_expected();
    check("pin_thr50", exp_out[6], 0);
    run_frame(1'b0);

    load_img(1, 49);
    build_expected();
    check("pin_thr49", exp_out[6], 255);
    run_frame(1'b0);

    // start ignored while unlocked
    chk_en = 1'b0;
    ra     = int'(rom_addr);
    snap   = vld_seen;
    locked = 1'b0;
    start  = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    repeat (10) tick();
    locked = 1'b1;
    repeat (5) tick();
    check("unlocked_rom_addr", int'(rom_addr), ra);
    check("unlocked_strobes", vld_seen, snap);
    check("unlocked_finished", int'(finished), 1);

    // RESET mid-frame
    load_img(3, 0);
    build_expected();
    start_frame();
    wait_strobes(40);
    chk_en = 1'b0;
    RESET  = 1'b1;
    tick();
    check("mid_rst_out", int'(out), 0);
    check("mid_rst_addr_edge", int'(addr_edge), 0);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_finished", int'(finished), 0);
    check("mid_rst_rom_addr", int'(rom_addr), 0);
    RESET = 1'b0;
    snap  = vld_seen;
    repeat (10) tick();
    check("post_rst_idle_addr", int'(rom_addr), 0);
    check("post_rst_idle_strobes", vld_seen, snap);
    run_frame(1'b0);

    // locked dropped mid-frame
    load_img(3, 0);
    build_expected();
    start_frame();
    wait_strobes(30);
    locked = 1'b0;
    tick();
    snap = vld_seen;
    repeat (40) tick();
    check("abort_strobes", vld_seen, snap);
    check("abort_finished", int'(finished), 0);
    locked = 1'b1;
    repeat (3) tick();
    check("abort_idle_strobes", vld_seen, snap);
    run_frame(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
